ring_fifo: RTL and testbench

RING_FIFO -- requirements
Module: ring_fifo

---
 rtl/ring_fifo.sv | 96 +++++++++
 tb/tb_ring_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ring_fifo.sv
// Single-clock circular FIFO with registered read data, full/empty status,
// occupancy count and a sticky overflow flag for pushes attempted while full.
module ring_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [WIDTH-1:0]             pushData_i,
  input  logic                         pushEnable_i,
  output logic                         pushFull_o,
  input  logic                         pollEnable_i,
  output logic                         pollBusy_o,
  output logic [WIDTH-1:0]             pollData_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] pollData_q, pollData_d;
  logic             overflow_q, overflow_d;

  logic             full, empty;
  logic             pushAccept, pollAccept;

  // Status comes from registered occupancy only, so neither flag depends on the inputs.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign pushAccept = pushEnable_i & ~full;
  assign pollAccept = pollEnable_i & ~empty;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    pollData_d = pollData_q;
    overflow_d = overflow_q;

    if (pushAccept) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end

    if (pollAccept) begin
      pollData_d = mem_q[rdPtr_q];
      rdPtr_d    = rdPtr_q + AW'(1);
    end

    unique case ({pushAccept, pollAccept})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (pushEnable_i && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      pollData_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      pollData_q <= pollData_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (pushAccept) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  assign pushFull_o = full;
  assign pollBusy_o = empty;
  assign pollData_o = pollData_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ring_fifo.sv
// Randomised and directed bench for ring_fifo, checked every cycle against a
// queue-based model plus literal expectations for the documented scenarios.
module tb_ring_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] pushData = '0;
  logic             pushEnable = 1'b0;
  logic             pollEnable = 1'b0;
  logic             pushFull;
  logic             pollBusy;
  logic [WIDTH-1:0] pollData;
  logic [LW-1:0]    level;
  logic             overflow;

  int vectors = 0;
  int miscompares = 0;

  ring_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pushData_i   (pushData),
    .pushEnable_i (pushEnable),
    .pushFull_o   (pushFull),
    .pollEnable_i (pollEnable),
    .pollBusy_o   (pollBusy),
    .pollData_o   (pollData),
    .level_o      (level),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue; acceptance decided from the occupancy before the edge.
  logic [WIDTH-1:0] mQ [$];
  logic [WIDTH-1:0] mData = '0;
  bit               mOvf = 1'b0;
  bit               mFull, mEmpty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mQ.delete();
      mData = '0;
      mOvf  = 1'b0;
    end else begin
      mFull  = (mQ.size() == DEPTH);
      mEmpty = (mQ.size() == 0);
      if (pollEnable && !mEmpty) mData = mQ.pop_front();
      if (pushEnable) begin
        if (mFull) mOvf = 1'b1;
        else       mQ.push_back(pushData);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("level",    32'(level),    32'(mQ.size()));
      checkOutput("full",     32'(pushFull), 32'(mQ.size() == DEPTH));
      checkOutput("busy",     32'(pollBusy), 32'(mQ.size() == 0));
      checkOutput("pollData", 32'(pollData), 32'(mData));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
    end
  end

  task automatic applyStimulus(input bit pe, input logic [WIDTH-1:0] d, input bit po);
    pushEnable = pe;
    pushData   = d;
    pollEnable = po;
    @(negedge clk);
  endtask

  task automatic doReset();
    pushEnable = 1'b0;
    pollEnable = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    // Reset is observable before any clock edge.
    #3;
    checkOutput("rst level",    32'(level),    32'h0);
    checkOutput("rst busy",     32'(pollBusy), 32'h1);
    checkOutput("rst full",     32'(pushFull), 32'h0);
    checkOutput("rst pollData", 32'(pollData), 32'h0);
    checkOutput("rst overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;

    $display("[TB] basic order");
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0);
    checkOutput("basic level3", 32'(level), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("basic data", 32'(pollData), 32'(i));
      checkOutput("basic level", 32'(level), 32'(3 - i));
    end

    $display("[TB] fill and overflow");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, WIDTH'(16'h0010 + i), 1'b0);
      if (i == 7) checkOutput("fill full8", 32'(pushFull), 32'h1);
      if (i == 7) checkOutput("fill ovf8", 32'(overflow), 32'h0);
    end
    checkOutput("fill ovf9", 32'(overflow), 32'h1);
    checkOutput("fill level9", 32'(level), 32'd8);

    $display("[TB] full with push and poll");
    applyStimulus(1'b1, 16'h00AA, 1'b1);
    checkOutput("fullpp data", 32'(pollData), 32'h0010);
    checkOutput("fullpp level", 32'(level), 32'd7);
    checkOutput("fullpp ovf", 32'(overflow), 32'h1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("drain data", 32'(pollData), 32'(16'h0010 + i));
    end
    checkOutput("drain busy", 32'(pollBusy), 32'h1);

    $display("[TB] empty with push and poll");
    doReset();
    applyStimulus(1'b1, 16'h00CC, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("prime data", 32'(pollData), 32'h00CC);
    applyStimulus(1'b1, 16'h0055, 1'b1);
    checkOutput("emptypp data", 32'(pollData), 32'h00CC);
    checkOutput("emptypp level", 32'(level), 32'd1);
    checkOutput("emptypp ovf", 32'(overflow), 32'h0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("emptypp poll", 32'(pollData), 32'h0055);

    $display("[TB] streaming across wrap");
    applyStimulus(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), 1'b1);
      checkOutput("stream level", 32'(level), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      int pushPct;
      pushPct = ((i / 100) % 2 == 0) ? 75 : 25;
      applyStimulus($urandom_range(99) < pushPct, WIDTH'($urandom), $urandom_range(99) >= pushPct);
    end

    $display("[TB] reset mid-stream");
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("pre-rst level", 32'(level), 32'd5);
    checkOutput("pre-rst ovf", 32'(overflow), 32'h1);
    pollEnable = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    pollEnable = 1'b0;
    #1;
    checkOutput("midrst level", 32'(level), 32'h0);
    checkOutput("midrst data", 32'(pollData), 32'h0);
    checkOutput("midrst ovf", 32'(overflow), 32'h0);
    checkOutput("midrst busy", 32'(pollBusy), 32'h1);
    checkOutput("midrst full", 32'(pushFull), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("postrst data", 32'(pollData), 32'h0);
    checkOutput("postrst level", 32'(level), 32'h0);
    checkOutput("postrst busy", 32'(pollBusy), 32'h1);
    applyStimulus(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
